// File: rtl/ram_scan_pkg.sv
// Shared types and expected-data generator for the RAM self-test sequencer.
package ram_scan_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      PAT_ADDR    = 2'b00,
      PAT_NADDR   = 2'b01,
      PAT_CHECKER = 2'b10,
      PAT_ZERO    = 2'b11
   } pattern_e;

   localparam logic [7:0] PAT_55 = 8'h55;
   localparam logic [7:0] PAT_AA = 8'hAA;
   localparam int         EXP_W  = 64;

   // Result is EXP_W wide; callers truncate to their DATA_W.
   function automatic logic [EXP_W-1:0] exp_data(input logic [1:0] pat,
                                                 input logic [EXP_W-1:0] addr);
      logic [EXP_W-1:0] r;
      case (pattern_e'(pat))
         PAT_ADDR:    r = addr;
         PAT_NADDR:   r = ~addr;
         PAT_CHECKER: r = addr[0] ? {8{PAT_AA}} : {8{PAT_55}};
         default:     r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ram_scan_ctrl_if.sv
// Single-port synchronous RAM access bus between the scan controller and the RAM.
interface ram_scan_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport slave (
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/ram_scan_ctrl_tick_gen.sv
// Clock-enable generator: one-cycle tick every TICK_DIV cycles while run is high.
module tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_clk,
   input  logic run,
   input  logic clr,
   output logic tick
);
   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         if (cnt_q == LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_clk) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ram_scan_ctrl.sv
// RAM self-test sequencer: write a pattern everywhere, read back, count mismatches.
// Define RAM_SCAN_ERR_CAPTURE_EN to add first-mismatch address/data capture ports.
module ram_scan_ctrl
   import ram_scan_pkg::*;
#(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int TICK_DIV = 50000,
   parameter int RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst_clk,
   input  logic              start,
   input  logic [1:0]        pattern,
   ram_scan_ctrl_if.master   ram,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] cur_addr
`ifdef RAM_SCAN_ERR_CAPTURE_EN
   ,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data
`endif
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   err_q, err_d;
   logic [1:0]        pat_q, pat_d;
   logic [1:0]        wait_q, wait_d;
   logic              en_q, en_d, we_q, we_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              tick, start_acc, mism;
   logic [DATA_W-1:0] exp_w;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .rst_clk (rst_clk),
      .run     (busy),
      .clr     (start_acc),
      .tick    (tick)
   );

   assign exp_w = DATA_W'(exp_data(pat_q, EXP_W'(addr_q)));
   assign mism  = (state_q == S_CHECK) && (ram.ram_rdata != exp_w);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      err_d     = err_q;
      pat_d     = pat_q;
      wait_d    = wait_q;
      en_d      = 1'b0;
      we_d      = 1'b0;
      wdata_d   = '0;
      raddr_d   = addr_q;
      start_acc = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               start_acc = 1'b1;
               pat_d     = pattern;
               addr_d    = '0;
               err_d     = '0;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            if (tick) begin
               en_d    = 1'b1;
               we_d    = 1'b1;
               wdata_d = exp_w;
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  state_d = S_READ;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         S_READ: begin
            if (tick) begin
               en_d    = 1'b1;
               wait_d  = '0;
               state_d = S_WAIT;
            end
         end
         // Strobe goes out the cycle WAIT is entered, so RD_LAT cycles here lands CHECK on valid data.
         S_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = S_CHECK;
            else                     wait_d  = wait_q + 1'b1;
         end
         S_CHECK: begin
            if (mism) err_d = err_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_clk) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         err_q   <= '0;
         pat_q   <= '0;
         wait_q  <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         raddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         pat_q   <= pat_d;
         wait_q  <= wait_d;
         en_q    <= en_d;
         we_q    <= we_d;
         raddr_q <= raddr_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef RAM_SCAN_ERR_CAPTURE_EN
   logic              fe_vld_q;
   logic [ADDR_W-1:0] fe_addr_q;
   logic [DATA_W-1:0] fe_data_q;

   always_ff @(posedge clk) begin
      if (rst_clk || start_acc) begin
         fe_vld_q  <= 1'b0;
         fe_addr_q <= '0;
         fe_data_q <= '0;
      end else if (mism && !fe_vld_q) begin
         fe_vld_q  <= 1'b1;
         fe_addr_q <= addr_q;
         fe_data_q <= exp_w;
      end
   end

   assign first_err_addr = fe_addr_q;
   assign first_err_data = fe_data_q;
`endif

   assign ram.ram_en    = en_q;
   assign ram.ram_we    = we_q;
   assign ram.ram_addr  = raddr_q;
   assign ram.ram_wdata = wdata_q;

   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = (state_q == S_DONE);
   assign pass     = done && (err_q == '0);
   assign err_cnt  = err_q;
   assign cur_addr = addr_q;
endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Randomized bench for ram_scan_ctrl with a behavioural RAM and a strobe-level reference model.
module tb_ram_scan_ctrl;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int TD    = 4;
   localparam int RL    = 1;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_clk, start;
   logic [1:0]    pattern;
   logic          busy, done, pass;
   logic [AW:0]   err_cnt;
   logic [AW-1:0] cur_addr;
`ifdef RAM_SCAN_ERR_CAPTURE_EN
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_data;
`endif

   ram_scan_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) rif ();

   ram_scan_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD), .RD_LAT(RL)) dut (
      .clk      (clk),
      .rst_clk  (rst_clk),
      .start    (start),
      .pattern  (pattern),
      .ram      (rif),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_cnt  (err_cnt),
      .cur_addr (cur_addr)
`ifdef RAM_SCAN_ERR_CAPTURE_EN
      ,
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural RAM, read latency 1; flip[] XORs read data to plant faults.
   logic [DW-1:0] mem  [DEPTH];
   logic [DW-1:0] flip [DEPTH];
   always @(posedge clk) begin
      if (rif.ram_en && rif.ram_we)  mem[rif.ram_addr] <= rif.ram_wdata;
      if (rif.ram_en && !rif.ram_we) rif.ram_rdata <= mem[rif.ram_addr] ^ flip[rif.ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int t;
      int we;
      int a;
      int d;
   } strobe_t;
   strobe_t sq[$];
   strobe_t s_mon;
   always @(negedge clk) begin
      if (rif.ram_en) begin
         s_mon.t  = cyc;
         s_mon.we = int'(rif.ram_we);
         s_mon.a  = int'(rif.ram_addr);
         s_mon.d  = int'(rif.ram_wdata);
         sq.push_back(s_mon);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int mexp(input int pat, input int a);
      case (pat)
         0:       return a;
         1:       return (255 - a);
         2:       return (a % 2 == 1) ? 'hAA : 'h55;
         default: return 0;
      endcase
   endfunction

   // Every strobe of a scan lands TICK_DIV cycles after the previous one.
   task automatic verify(input int pat, input int t0);
      int we_e, a_e;
      chk("n_strobes", sq.size(), 2 * DEPTH);
      for (int i = 0; i < 2 * DEPTH && i < sq.size(); i++) begin
         we_e = (i < DEPTH) ? 1 : 0;
         a_e  = i % DEPTH;
         chk("strobe_we", sq[i].we, we_e);
         chk("strobe_addr", sq[i].a, a_e);
         chk("strobe_wdata", sq[i].d, (we_e != 0) ? mexp(pat, a_e) : 0);
         chk("strobe_time", sq[i].t, t0 + TD * (i + 1));
      end
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 2000 && !seen; k++) begin
         @(negedge clk);
         seen = done;
      end
      chk(tag, int'(seen), 1);
   endtask

   task automatic scan(input int pat, input bit hold);
      int t0;
      int nexp  = 0;
      int first = -1;
      for (int a = 0; a < DEPTH; a++)
         if (flip[a] != 0) begin
            nexp++;
            if (first < 0) first = a;
         end
      sq.delete();
      pattern = 2'(pat);
      start   = 1'b1;
      t0      = cyc + 1;
      @(negedge clk);
      chk("start_busy", busy, 1);
      chk("start_err0", err_cnt, 0);
      chk("start_addr0", cur_addr, 0);
      if (!hold) start = 1'b0;
      pattern = 2'($urandom);
      wait_done("done_timeout");
      verify(pat, t0);
      chk("done_busy", busy, 0);
      chk("err_cnt", err_cnt, nexp);
      chk("pass", pass, (nexp == 0) ? 1 : 0);
`ifdef RAM_SCAN_ERR_CAPTURE_EN
      chk("first_err_addr", first_err_addr, (nexp != 0) ? first : 0);
      chk("first_err_data", first_err_data, (nexp != 0) ? mexp(pat, first) : 0);
`endif
      if (hold) begin
         @(negedge clk);
         chk("restart_busy", busy, 1);
         chk("restart_done", done, 0);
         chk("restart_err0", err_cnt, 0);
         start = 1'b0;
         wait_done("restart_timeout");
      end
   endtask

   initial begin
      bit seen;
      int n;
      rst_clk = 1'b1;
      start   = 1'b0;
      pattern = 2'b00;
      for (int a = 0; a < DEPTH; a++) flip[a] = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_cur_addr", cur_addr, 0);
      chk("rst_ram_en", rif.ram_en, 0);
      chk("rst_ram_we", rif.ram_we, 0);
      chk("rst_ram_addr", rif.ram_addr, 0);
      chk("rst_ram_wdata", rif.ram_wdata, 0);

      rst_clk = 1'b0;
      sq.delete();
      repeat (10) @(negedge clk);
      chk("idle_no_strobe", sq.size(), 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);

      scan(0, 1'b0);
      scan(2, 1'b0);

      // ~5 = 0xFA already has bit0 clear, so flip bit0 to make the fault visible.
      flip[5] = 8'h01;
      scan(1, 1'b0);
      flip[5] = 8'h00;

      flip[3] = 8'h10;
      scan(0, 1'b1);
      flip[3] = 8'h00;

      repeat (6) begin
         for (int a = 0; a < DEPTH; a++)
            flip[a] = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         scan(int'($urandom_range(0, 3)), 1'b0);
      end
      for (int a = 0; a < DEPTH; a++) flip[a] = '0;

      // Reset (with start asserted alongside) while in READ at address 7.
      flip[2] = 8'h80;
      sq.delete();
      pattern = 2'b00;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 2000 && !seen; k++) begin
         @(negedge clk);
         seen = (sq.size() == DEPTH + 7) && (cur_addr == 7);
      end
      chk("rd7_reached", int'(seen), 1);
      chk("rd7_err_before_rst", err_cnt, 1);
      rst_clk = 1'b1;
      start   = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_ram_en", rif.ram_en, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err", err_cnt, 0);
      chk("midrst_cur_addr", cur_addr, 0);
      rst_clk = 1'b0;
      start   = 1'b0;
      n = sq.size();
      repeat (12) @(negedge clk);
      chk("midrst_no_strobe", sq.size(), n);
      chk("midrst_idle", busy, 0);
      flip[2] = 8'h00;

      scan(3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
